vanilla_wb_port_scheduler: RTL and testbench
============================================

Name: vanilla_wb_port_scheduler

Overview:
Schedules the shared integer register-file write port of the vanilla core among three writers, then issues the matching scoreboard clear.
- Writers: the in-order pipeline writeback (highest priority), remote-load responses and the iterative idiv unit.
- Scoreboard clear: drives int_sb_clear/int_sb_clear_id so in-flight scoreboard bits drop on the same cycle the data lands.
- Starvation guard: if the long-latency sources are locked out too long, it requests a one-port pipeline writeback stall.
- The float side instantiates the same block with fdiv/fsqrt in the idiv slot.

Parameters:
data_width_p, 32, writeback data width
reg_addr_width_p, 5, register index width
starve_limit_p, 4, consecutive blocked cycles (>=1) before a pipeline writeback stall is requested

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
pipe_wb_v_i  in  1  pipeline wants the port this cycle
remote_v_i  in  1  remote load response valid
remote_id_i  in  reg_addr_width_p  destination register of remote response
remote_data_i  in  data_width_p  remote response data
remote_yumi_o  out  1  remote response consumed this cycle
idiv_v_i  in  1  idiv result valid
idiv_id_i  in  reg_addr_width_p  idiv destination register
idiv_data_i  in  data_width_p  idiv result
idiv_yumi_o  out  1  idiv result consumed this cycle
side_wb_v_o  out  1  side writer owns the port this cycle
side_wb_id_o  out  reg_addr_width_p  side write register index
side_wb_data_o  out  data_width_p  side write data
sb_clear_o  out  1  scoreboard clear strobe
sb_clear_id_o  out  reg_addr_width_p  scoreboard clear index
stall_pipe_wb_o  out  1  registered; pipeline must hold its writeback this cycle

Behaviour:
- Clock and reset: one clock (clk_i); reset_i is synchronous, active-high.
- Source handshake: valid/yumi. The source holds v/id/data stable until yumi. The yumi outputs are combinational from the v inputs and registered state.
- port_free = ~pipe_wb_v_i | stall_pipe_wb_o.
- Arbitration when port_free:
  - If exactly one source is valid, grant it.
  - If both are valid, grant by 2-way round-robin. rr_r points to the preferred source and flips to the other source after every grant.
- Grant, same cycle:
  - yumi_o=1 for the granted source only.
  - side_wb_v_o=1, with side_wb_id_o/side_wb_data_o muxed from the granted source.
  - sb_clear_o=1, sb_clear_id_o = granted id.
  - Zero added latency.
- When not port_free, or no source is valid: no grant, all of the above are 0. side_wb_id_o, side_wb_data_o and sb_clear_id_o are don't-care when their valid/strobe is 0.
- Starvation FSM, counter cnt_r saturating at starve_limit_p, width clog2(starve_limit_p+1):
  - IDLE (cnt_r=0):
    - any source valid and not granted -> WAIT, cnt_r=1
    - otherwise stay
  - WAIT:
    - grant -> IDLE, cnt_r=0
    - blocked and cnt_r+1 == starve_limit_p -> STALL
    - blocked otherwise -> cnt_r++
    - no source valid -> IDLE
  - STALL: stall_pipe_wb_o=1 (registered state output). A grant is guaranteed, since port_free=1 and a source is still valid. Next state IDLE with cnt_r=0.
  - A stall lasts exactly one cycle per starvation episode.
- The pipeline's pipe_wb_v_i is ignored for arbitration while stall_pipe_wb_o=1; the pipeline retries next cycle.
- Same id on both sources simultaneously: no merging. Each is granted separately and each issues its own clear.
- Reset values:
  - all outputs 0
  - FSM IDLE, cnt_r=0
  - rr_r prefers remote
- Reset mid-operation: state and counter cleared, outputs 0 during the reset cycle. Pending sources keep valid asserted and are arbitrated from the first post-reset cycle.
- No internal data storage.

Test Plan:
- Only remote_v_i=1, id=7, data=0xDEADBEEF, pipe_wb_v_i=0 -> same cycle: remote_yumi_o=1, side_wb_v_o=1, side_wb_id_o=7, side_wb_data_o=0xDEADBEEF, sb_clear_o=1, sb_clear_id_o=7.
- Both sources valid every cycle for 4 free cycles starting after reset -> grants remote, idiv, remote, idiv; never both yumi in one cycle.
- pipe_wb_v_i held 1 and idiv_v_i=1 (id=3), starve_limit_p=4:
  - idiv_yumi_o=0 for 4 cycles.
  - stall_pipe_wb_o=1 on the 5th cycle, with idiv granted that cycle (sb_clear_id_o=3).
  - stall_pipe_wb_o returns to 0 the following cycle.
- Same setup, but pipe_wb_v_i drops to 0 on the 3rd cycle -> idiv granted then, no stall, cnt_r back to 0.
- reset_i asserted in WAIT with cnt_r=2 -> next cycle stall_pipe_wb_o=0, cnt_r=0, rr prefers remote. A still-pending source counts from 1 again.
- remote and idiv both valid with id=5 -> two separate grants, two sb_clear_o pulses with id 5 in consecutive free cycles.

Source files
------------

// File: rtl/vanilla_wb_port_scheduler.sv
// Shares the integer register-file write port between the pipeline writeback,
// remote-load responses and the idiv unit, and issues the matching scoreboard clear.
module vanilla_wb_port_scheduler #(
   parameter int data_width_p     = 32,
   parameter int reg_addr_width_p = 5,
   parameter int starve_limit_p   = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        pipe_wb_v_i,
   input  logic                        remote_v_i,
   input  logic [reg_addr_width_p-1:0] remote_id_i,
   input  logic [data_width_p-1:0]     remote_data_i,
   output logic                        remote_yumi_o,
   input  logic                        idiv_v_i,
   input  logic [reg_addr_width_p-1:0] idiv_id_i,
   input  logic [data_width_p-1:0]     idiv_data_i,
   output logic                        idiv_yumi_o,
   output logic                        side_wb_v_o,
   output logic [reg_addr_width_p-1:0] side_wb_id_o,
   output logic [data_width_p-1:0]     side_wb_data_o,
   output logic                        sb_clear_o,
   output logic [reg_addr_width_p-1:0] sb_clear_id_o,
   output logic                        stall_pipe_wb_o
);

   localparam int unsigned cnt_w_lp = $clog2(starve_limit_p + 1);
   localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

   // Bit 1 of the state is the stall flag, so the stall output comes straight from a flop.
   localparam logic [1:0] idle_s  = 2'b00;
   localparam logic [1:0] wait_s  = 2'b01;
   localparam logic [1:0] stall_s = 2'b10;

   logic [1:0]          state_r, state_n;
   logic [cnt_w_lp-1:0] cnt_r, cnt_n, cnt_inc;
   logic                rr_idiv_r;
   logic                port_free, grant_remote, grant_idiv, any_grant, any_v;

   // Gated by reset so every output reads 0 during a reset cycle.
   assign stall_pipe_wb_o = state_r[1] & ~reset_i;
   assign port_free       = ~pipe_wb_v_i | stall_pipe_wb_o;

   assign grant_remote = ~reset_i & port_free & remote_v_i & (~idiv_v_i | ~rr_idiv_r);
   assign grant_idiv   = ~reset_i & port_free & idiv_v_i & (~remote_v_i | rr_idiv_r);
   assign any_grant    = grant_remote | grant_idiv;
   assign any_v        = remote_v_i | idiv_v_i;

   assign remote_yumi_o  = grant_remote;
   assign idiv_yumi_o    = grant_idiv;
   assign side_wb_v_o    = any_grant;
   assign side_wb_id_o   = grant_idiv ? idiv_id_i : remote_id_i;
   assign side_wb_data_o = grant_idiv ? idiv_data_i : remote_data_i;
   assign sb_clear_o     = any_grant;
   assign sb_clear_id_o  = side_wb_id_o;

   assign cnt_inc = cnt_r + 1'b1;

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      case (state_r)
         idle_s, wait_s: begin
            if (any_grant || !any_v) begin
               state_n = idle_s;
               cnt_n   = '0;
            end else if (cnt_inc >= limit_lp) begin
               state_n = stall_s;
               cnt_n   = cnt_inc;
            end else begin
               state_n = wait_s;
               cnt_n   = cnt_inc;
            end
         end
         default: begin
            state_n = idle_s;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r   <= idle_s;
         cnt_r     <= '0;
         rr_idiv_r <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         if (any_grant)
            rr_idiv_r <= grant_remote;
      end
   end

endmodule

// File: tb/tb_vanilla_wb_port_scheduler.sv
// Self-checking bench for vanilla_wb_port_scheduler: directed scenarios with literal
// expectations plus randomized traffic compared against a cycle-level behavioural model.
module tb_vanilla_wb_port_scheduler;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int LIM = 4;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          pipe_wb_v_i;
   logic          remote_v_i;
   logic [AW-1:0] remote_id_i;
   logic [DW-1:0] remote_data_i;
   logic          remote_yumi_o;
   logic          idiv_v_i;
   logic [AW-1:0] idiv_id_i;
   logic [DW-1:0] idiv_data_i;
   logic          idiv_yumi_o;
   logic          side_wb_v_o;
   logic [AW-1:0] side_wb_id_o;
   logic [DW-1:0] side_wb_data_o;
   logic          sb_clear_o;
   logic [AW-1:0] sb_clear_id_o;
   logic          stall_pipe_wb_o;

   always #5 clk_i = ~clk_i;

   vanilla_wb_port_scheduler #(
      .data_width_p(DW),
      .reg_addr_width_p(AW),
      .starve_limit_p(LIM)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .pipe_wb_v_i(pipe_wb_v_i),
      .remote_v_i(remote_v_i),
      .remote_id_i(remote_id_i),
      .remote_data_i(remote_data_i),
      .remote_yumi_o(remote_yumi_o),
      .idiv_v_i(idiv_v_i),
      .idiv_id_i(idiv_id_i),
      .idiv_data_i(idiv_data_i),
      .idiv_yumi_o(idiv_yumi_o),
      .side_wb_v_o(side_wb_v_o),
      .side_wb_id_o(side_wb_id_o),
      .side_wb_data_o(side_wb_data_o),
      .sb_clear_o(sb_clear_o),
      .sb_clear_id_o(sb_clear_id_o),
      .stall_pipe_wb_o(stall_pipe_wb_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model state: blocked-cycle run length, pending stall, and which source wins a tie.
   int   m_run;
   logic m_stall;
   logic m_pref_idiv;
   logic m_free, m_gr, m_gi;

   always @(negedge clk_i) begin
      if (reset_i) begin
         check("rst_remote_yumi", remote_yumi_o, 0);
         check("rst_idiv_yumi", idiv_yumi_o, 0);
         check("rst_side_v", side_wb_v_o, 0);
         check("rst_sb_clear", sb_clear_o, 0);
         check("rst_stall", stall_pipe_wb_o, 0);
         m_run = 0; m_stall = 1'b0; m_pref_idiv = 1'b0;
      end else begin
         m_free = !pipe_wb_v_i || m_stall;
         m_gr   = m_free && remote_v_i && (!idiv_v_i || !m_pref_idiv);
         m_gi   = m_free && idiv_v_i && (!remote_v_i || m_pref_idiv);
         check("m_stall", stall_pipe_wb_o, m_stall);
         check("m_remote_yumi", remote_yumi_o, m_gr);
         check("m_idiv_yumi", idiv_yumi_o, m_gi);
         check("m_side_v", side_wb_v_o, m_gr || m_gi);
         check("m_sb_clear", sb_clear_o, m_gr || m_gi);
         if (m_gr || m_gi) begin
            check("m_side_id", side_wb_id_o, m_gr ? remote_id_i : idiv_id_i);
            check("m_side_data", side_wb_data_o, m_gr ? remote_data_i : idiv_data_i);
            check("m_clear_id", sb_clear_id_o, m_gr ? remote_id_i : idiv_id_i);
         end
         if (m_gr) m_pref_idiv = 1'b1;
         else if (m_gi) m_pref_idiv = 1'b0;
         if (m_stall) begin
            m_stall = 1'b0; m_run = 0;
         end else if (m_gr || m_gi || !(remote_v_i || idiv_v_i)) begin
            m_run = 0;
         end else begin
            m_run++;
            if (m_run == LIM) begin m_stall = 1'b1; m_run = 0; end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk_i); #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1; pipe_wb_v_i = 1'b0; remote_v_i = 1'b0; idiv_v_i = 1'b0;
      next_cycle();
      reset_i = 1'b0;
   endtask

   logic r_taken, i_taken;

   initial begin
      reset_i = 1'b1; pipe_wb_v_i = 1'b0;
      remote_v_i = 1'b0; remote_id_i = '0; remote_data_i = '0;
      idiv_v_i = 1'b0; idiv_id_i = '0; idiv_data_i = '0;
      @(negedge clk_i);
      check("reset_stall", stall_pipe_wb_o, 0);
      next_cycle(); next_cycle();

      // Single remote response, zero-latency grant.
      reset_i = 1'b0;
      remote_v_i = 1'b1; remote_id_i = 5'd7; remote_data_i = 32'hDEADBEEF;
      @(negedge clk_i);
      check("a_yumi", remote_yumi_o, 1);
      check("a_side_v", side_wb_v_o, 1);
      check("a_side_id", side_wb_id_o, 7);
      check("a_side_data", side_wb_data_o, 32'hDEADBEEF);
      check("a_clear", sb_clear_o, 1);
      check("a_clear_id", sb_clear_id_o, 7);
      next_cycle();

      // Both valid every free cycle: strict alternation starting with remote.
      do_reset();
      remote_v_i = 1'b1; idiv_v_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         remote_id_i = AW'(i + 1); idiv_id_i = AW'(i + 11);
         @(negedge clk_i);
         check("b_remote_yumi", remote_yumi_o, (i % 2 == 0) ? 1 : 0);
         check("b_idiv_yumi", idiv_yumi_o, (i % 2 == 1) ? 1 : 0);
         next_cycle();
      end

      // Pipeline hogs the port: four blocked cycles, then a one-cycle stall.
      do_reset();
      pipe_wb_v_i = 1'b1; idiv_v_i = 1'b1; idiv_id_i = 5'd3; idiv_data_i = 32'h33;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_i);
         if (i < 5) begin
            check("c_idiv_blocked", idiv_yumi_o, 0);
            check("c_no_stall", stall_pipe_wb_o, 0);
         end else begin
            check("c_stall", stall_pipe_wb_o, 1);
            check("c_idiv_yumi", idiv_yumi_o, 1);
            check("c_clear_id", sb_clear_id_o, 3);
         end
         next_cycle();
      end
      idiv_v_i = 1'b0;
      @(negedge clk_i);
      check("c_stall_drop", stall_pipe_wb_o, 0);
      next_cycle();

      // Pipeline frees the port on the third cycle: no stall, counter restarts.
      do_reset();
      pipe_wb_v_i = 1'b1; idiv_v_i = 1'b1; idiv_id_i = 5'd3;
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) pipe_wb_v_i = 1'b0;
         @(negedge clk_i);
         check("d_idiv_yumi", idiv_yumi_o, (i == 3) ? 1 : 0);
         check("d_no_stall", stall_pipe_wb_o, 0);
         next_cycle();
      end
      pipe_wb_v_i = 1'b1; idiv_id_i = 5'd4;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_i);
         check("d_fresh_stall", stall_pipe_wb_o, (i == 5) ? 1 : 0);
         next_cycle();
      end
      idiv_v_i = 1'b0;

      // Reset while two cycles into a starvation episode.
      do_reset();
      pipe_wb_v_i = 1'b1; idiv_v_i = 1'b1; idiv_id_i = 5'd9;
      next_cycle(); next_cycle();
      reset_i = 1'b1;
      @(negedge clk_i);
      check("e_rst_yumi", idiv_yumi_o, 0);
      next_cycle();
      reset_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_i);
         check("e_stall", stall_pipe_wb_o, (i == 5) ? 1 : 0);
         check("e_yumi", idiv_yumi_o, (i == 5) ? 1 : 0);
         next_cycle();
      end
      idiv_v_i = 1'b0; pipe_wb_v_i = 1'b0;

      // Same destination on both sources: two separate grants and clears.
      do_reset();
      remote_v_i = 1'b1; remote_id_i = 5'd5; remote_data_i = 32'hA;
      idiv_v_i = 1'b1; idiv_id_i = 5'd5; idiv_data_i = 32'hB;
      @(negedge clk_i);
      check("f1_remote_yumi", remote_yumi_o, 1);
      check("f1_idiv_yumi", idiv_yumi_o, 0);
      check("f1_clear_id", sb_clear_id_o, 5);
      check("f1_data", side_wb_data_o, 32'hA);
      next_cycle();
      remote_v_i = 1'b0;
      @(negedge clk_i);
      check("f2_idiv_yumi", idiv_yumi_o, 1);
      check("f2_clear", sb_clear_o, 1);
      check("f2_clear_id", sb_clear_id_o, 5);
      check("f2_data", side_wb_data_o, 32'hB);
      next_cycle();
      idiv_v_i = 1'b0;

      // Randomized traffic honouring the valid/yumi hold rule.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_i);
         r_taken = remote_yumi_o;
         i_taken = idiv_yumi_o;
         next_cycle();
         reset_i     = ($urandom_range(0, 299) == 0);
         pipe_wb_v_i = ($urandom_range(0, 99) < 75);
         if (!remote_v_i || r_taken) begin
            remote_v_i    = ($urandom_range(0, 99) < 40);
            remote_id_i   = AW'($urandom);
            remote_data_i = $urandom;
         end
         if (!idiv_v_i || i_taken) begin
            idiv_v_i    = ($urandom_range(0, 99) < 40);
            idiv_id_i   = AW'($urandom);
            idiv_data_i = $urandom;
         end
      end
      @(negedge clk_i);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
